axi4_single_os_master: RTL and testbench
========================================

# axi4_single_os_master

Bridges a simple one-word request/response port onto an AXI4 master interface, issuing at most one read and no concurrent write (single outstanding transaction total). It is the upstream stage that drives the AXI4 bus checked by the single-outstanding AXI4 environment properties. Every transaction it emits satisfies those properties by construction:
- ID of the response matches the issued ID.
- No response is accepted without an outstanding request.
- At most one AR or AW/W is outstanding.

## Interface
- ID_W, 6, AXI ID width (arid/awid/rid/bid)
- ADDR_W, 32, address width
- DATA_W, 32, data width; single-beat only
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_rnw  in  1  1=read, 0=write
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  write strobes
- req_id  in  ID_W  transaction ID
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  AXI RESP of rresp/bresp, OR'd with 2'b10 on ID error
- rsp_id  out  ID_W  ID of completed transaction
- id_err  out  1  sticky ID-mismatch flag, cleared only by rst
- axi_if  master modport of axi_interface: AR, R, AW, W, B channels

## Operation
- States: IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch addr/wdata/be/id/rnw.
  - Go to RD_ADDR (rnw=1) or WR_REQ (rnw=0).
- RD_ADDR:
  - arvalid=1 with latched addr and id.
  - On arready go to RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: capture rdata, rresp, rid; go to IDLE.
- WR_REQ:
  - awvalid=1 and wvalid=1 in the same cycle.
  - Each valid drops independently once its handshake completes; track with aw_done and w_done.
  - When both are done (same cycle or different), go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: capture bresp, bid; go to IDLE.
- Fixed AXI fields:
  - arlen=awlen=0, arsize=awsize=log2(DATA_W/8), burst=INCR(01).
  - wlast=1.
  - cache, prot, lock = 0.
- Data never changes while the corresponding valid is high.
- rready and bready are 0 outside their response states, so stray responses are never accepted.

## Timing
- Reset values (async): state=IDLE, all AXI valids/readies=0, rsp_valid=0, rsp_* =0, id_err=0. req_ready=1 is combinational from IDLE.
- Read, with request accepted at cycle N:
  - arvalid rises at N+1.
  - arready at cycle A puts rready high at A+1.
  - rvalid&rready at cycle R gives rsp_valid at R+1, when req_ready is already 1.
  - Minimum read turnaround is 3 cycles request to response; back-to-back requests are accepted on the rsp_valid cycle.
- Write:
  - aw/w valids rise at N+1.
  - If aw and w are accepted in different cycles, bready rises the cycle after the later one.
  - B accepted at B gives rsp_valid at B+1.
- Reset mid-transaction: everything returns to IDLE immediately and the latched request is discarded. The system resets the slave together with this block.

## Configuration
- AXI_ID_CHECK_EN defined:
  - rid/bid is compared with the latched id.
  - A mismatch sets id_err (sticky) and forces rsp_resp[1]=1 (SLVERR/DECERR class).
  - rsp_id reports the latched id.
- AXI_ID_CHECK_EN not defined:
  - No compare; id_err is tied 0.
  - rsp_resp passes rresp/bresp unchanged.
  - rsp_id reports the latched id.

## Structure
- Shared package (cva5_types): state enum (5 states), AXI burst/size constants (BURST_INCR, resp codes OKAY/EXOKAY/SLVERR/DECERR).
- One sub-module, axi4_single_os_wr_tracker, holds aw_done/w_done and produces awvalid, wvalid and both_done. The top module holds the FSM, request latch and response register.

## Test plan
- Read: req addr=0x1000, id=5 → arvalid at N+1 with araddr=0x1000, arid=5, arlen=0. Slave returns rdata=0xDEADBEEF, rid=5, OKAY → rsp_valid 1 cycle, rsp_rdata=0xDEADBEEF, rsp_id=5, rsp_resp=0.
- Write with W accepted 2 cycles before AW: wdata=0x12345678, be=0xF → wvalid drops after its handshake, awvalid holds. bready rises 1 cycle after AW accept. bresp=OKAY → rsp_valid, rsp_resp=0.
- Back-to-back: a read then a write, each request presented the cycle rsp_valid is high → accepted that cycle with no idle cycle. No second arvalid/awvalid is issued while a transaction is outstanding.
- ID mismatch with AXI_ID_CHECK_EN: issue id=3, return rid=4 → rsp_resp=2'b10, id_err=1, which stays 1 through later good transactions. Without the macro: rsp_resp=0, id_err=0.
- Async reset asserted in RD_RESP between clock edges → arvalid/rready/rsp_valid drop immediately. After release, req_ready=1 and a new read completes normally.
- Stray rvalid/bvalid in IDLE → rready/bready stay 0 and no rsp_valid occurs.

Source files
------------

// File: rtl/cva5_types.sv
// Shared types and AXI constants for the single-outstanding AXI4 master.
// Optional feature macro used by the master: AXI_ID_CHECK_EN.
package cva5_types;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_RESP = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AxSIZE encoding for a full-width beat: log2 of the bytes per beat
    function automatic logic [2:0] axsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_interface.sv
// AXI4 bus bundle (AR, R, AW, W, B) with master/slave views.
interface axi_interface #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi4_single_os_wr_tracker.sv
// Tracks AW and W handshakes of one write independently; each valid drops
// once its own handshake completes, both_done flags the later of the two.
module axi4_single_os_wr_tracker (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_awready,
    input  logic i_wready,
    output logic o_awvalid,
    output logic o_wvalid,
    output logic o_both_done
);
    logic r_aw_done;
    logic r_w_done;
    logic w_aw_hs;
    logic w_w_hs;

    assign o_awvalid   = i_active && !r_aw_done;
    assign o_wvalid    = i_active && !r_w_done;
    assign w_aw_hs     = o_awvalid && i_awready;
    assign w_w_hs      = o_wvalid && i_wready;
    assign o_both_done = i_active && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    // Done flags: set on handshake, cleared whenever no write is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (!i_active) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
        end
    end

endmodule

// File: rtl/axi4_single_os_master.sv
// One-word request/response port to AXI4 master, single outstanding
// transaction. Optional ID checking of rid/bid: define AXI_ID_CHECK_EN.
module axi4_single_os_master
    import cva5_types::*;
#(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_rnw,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ID_W-1:0]     req_id,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic [ID_W-1:0]     rsp_id,
    output logic                id_err,
    axi_interface.master        axi_if
);
    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;
    logic [ID_W-1:0]     r_id;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_bready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [1:0]          r_rsp_resp;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_id_err;

    logic                w_awvalid;
    logic                w_wvalid;
    logic                w_both_done;
    logic                w_rid_bad;
    logic                w_bid_bad;

`ifdef AXI_ID_CHECK_EN
    assign w_rid_bad = (axi_if.rid != r_id);
    assign w_bid_bad = (axi_if.bid != r_id);
`else
    assign w_rid_bad = 1'b0;
    assign w_bid_bad = 1'b0;
    logic w_unused_ids;
    assign w_unused_ids = ^{axi_if.rid, axi_if.bid};
`endif

    // Single-beat reads always end on the only beat, so rlast carries no information
    logic w_unused_rlast;
    assign w_unused_rlast = axi_if.rlast;

    assign req_ready = (r_state == IDLE);

    axi4_single_os_wr_tracker u_wr_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_active    (r_state == WR_REQ),
        .i_awready   (axi_if.awready),
        .i_wready    (axi_if.wready),
        .o_awvalid   (w_awvalid),
        .o_wvalid    (w_wvalid),
        .o_both_done (w_both_done)
    );

    // Address/data come straight from the request latch, stable while valid
    assign axi_if.arid    = r_id;
    assign axi_if.araddr  = r_addr;
    assign axi_if.arlen   = 8'd0;
    assign axi_if.arsize  = axsize(DATA_W);
    assign axi_if.arburst = BURST_INCR;
    assign axi_if.arlock  = 1'b0;
    assign axi_if.arcache = 4'd0;
    assign axi_if.arprot  = 3'd0;
    assign axi_if.arvalid = r_arvalid;
    assign axi_if.rready  = r_rready;

    assign axi_if.awid    = r_id;
    assign axi_if.awaddr  = r_addr;
    assign axi_if.awlen   = 8'd0;
    assign axi_if.awsize  = axsize(DATA_W);
    assign axi_if.awburst = BURST_INCR;
    assign axi_if.awlock  = 1'b0;
    assign axi_if.awcache = 4'd0;
    assign axi_if.awprot  = 3'd0;
    assign axi_if.awvalid = w_awvalid;
    assign axi_if.wdata   = r_wdata;
    assign axi_if.wstrb   = r_be;
    assign axi_if.wlast   = 1'b1;
    assign axi_if.wvalid  = w_wvalid;
    assign axi_if.bready  = r_bready;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign rsp_id    = r_rsp_id;
    assign id_err    = r_id_err;

    // Transaction FSM with request latch and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_id        <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_rsp_id    <= '0;
            r_id_err    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_id    <= req_id;
                        if (req_rnw) begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end else begin
                            r_state   <= WR_REQ;
                        end
                    end
                end
                RD_ADDR: begin
                    if (axi_if.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi_if.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= axi_if.rdata;
                        r_rsp_resp  <= axi_if.rresp | {w_rid_bad, 1'b0};
                        r_rsp_id    <= r_id;
                        r_id_err    <= r_id_err | w_rid_bad;
                        r_state     <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (w_both_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_if.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= axi_if.bresp | {w_bid_bad, 1'b0};
                        r_rsp_id    <= r_id;
                        r_id_err    <= r_id_err | w_bid_bad;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_single_os_master.sv
// Directed bench for axi4_single_os_master; the bench plays the AXI slave.
module tb_axi4_single_os_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rnw = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic [5:0]  req_id = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [5:0]  rsp_id;
    logic        id_err;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef AXI_ID_CHECK_EN
    localparam logic [1:0] EXP_BAD_RESP = 2'b10;
    localparam logic       EXP_ERR      = 1'b1;
`else
    localparam logic [1:0] EXP_BAD_RESP = 2'b00;
    localparam logic       EXP_ERR      = 1'b0;
`endif

    axi_interface #(.ID_W(6), .ADDR_W(32), .DATA_W(32)) axi ();

    axi4_single_os_master #(.ID_W(6), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rnw   (req_rnw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_id    (req_id),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .rsp_id    (rsp_id),
        .id_err    (id_err),
        .axi_if    (axi)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;
    endtask

    task automatic put_req(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input logic [5:0] id);
        req_valid = 1; req_rnw = rnw; req_addr = addr; req_wdata = wd; req_be = be; req_id = id;
    endtask

    task automatic test_reset();
        rst = 0; #1 rst = 1; #2;
        n_chk++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0)
            $display("FAIL reset_valids: got %b exp 00000", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); else n_pass++;
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
        n_chk++; if ({rsp_rdata, rsp_resp, rsp_id} !== 40'h0) $display("FAIL reset_rsp_fields: got %h exp 0", {rsp_rdata, rsp_resp, rsp_id}); else n_pass++;
        n_chk++; if (id_err !== 1'b0) $display("FAIL reset_id_err: got %b exp 0", id_err); else n_pass++;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b exp 1", req_ready); else n_pass++;
        @(negedge clk); rst = 0;
        step();
    endtask

    task automatic test_read();
        put_req(1, 32'h1000, 32'h0, 4'h0, 6'd5);
        n_chk++; if (req_ready !== 1'b1) $display("FAIL rd_req_ready_idle: got %b exp 1", req_ready); else n_pass++;
        step(); req_valid = 0;
        n_chk++; if (axi.arvalid !== 1'b1) $display("FAIL rd_arvalid_rise: got %b exp 1", axi.arvalid); else n_pass++;
        n_chk++; if (axi.araddr !== 32'h1000) $display("FAIL rd_araddr: got %h exp 00001000", axi.araddr); else n_pass++;
        n_chk++; if (axi.arid !== 6'd5) $display("FAIL rd_arid: got %0d exp 5", axi.arid); else n_pass++;
        n_chk++; if ({axi.arlen, axi.arsize, axi.arburst} !== {8'd0, 3'd2, 2'b01})
            $display("FAIL rd_ar_fixed: got len %0d size %0d burst %0d exp 0 2 1", axi.arlen, axi.arsize, axi.arburst); else n_pass++;
        n_chk++; if ({req_ready, axi.rready} !== 2'b00) $display("FAIL rd_busy: got ready/rready %b exp 00", {req_ready, axi.rready}); else n_pass++;
        step();
        n_chk++; if (axi.arvalid !== 1'b1) $display("FAIL rd_arvalid_hold: got %b exp 1", axi.arvalid); else n_pass++;
        axi.arready = 1; step(); axi.arready = 0;
        n_chk++; if ({axi.arvalid, axi.rready} !== 2'b01) $display("FAIL rd_after_ar: got arvalid/rready %b exp 01", {axi.arvalid, axi.rready}); else n_pass++;
        axi.rvalid = 1; axi.rdata = 32'hDEADBEEF; axi.rid = 6'd5; axi.rresp = 2'b00;
        step(); axi.rvalid = 0;
        n_chk++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid: got %b exp 1", rsp_valid); else n_pass++;
        n_chk++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL rd_rsp_rdata: got %h exp deadbeef", rsp_rdata); else n_pass++;
        n_chk++; if ({rsp_id, rsp_resp} !== {6'd5, 2'b00}) $display("FAIL rd_rsp_id_resp: got id %0d resp %0d exp 5 0", rsp_id, rsp_resp); else n_pass++;
        n_chk++; if ({req_ready, axi.rready} !== 2'b10) $display("FAIL rd_done_ready: got ready/rready %b exp 10", {req_ready, axi.rready}); else n_pass++;
        step();
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_pulse: got %b exp 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_write_w_first();
        put_req(0, 32'h2000, 32'h12345678, 4'hF, 6'd9);
        step(); req_valid = 0;
        n_chk++; if ({axi.awvalid, axi.wvalid, axi.wlast} !== 3'b111) $display("FAIL wr_valids_rise: got %b exp 111", {axi.awvalid, axi.wvalid, axi.wlast}); else n_pass++;
        n_chk++; if ({axi.awaddr, axi.awid, axi.awlen} !== {32'h2000, 6'd9, 8'd0}) $display("FAIL wr_aw_fields: got %h %0d %0d", axi.awaddr, axi.awid, axi.awlen); else n_pass++;
        n_chk++; if ({axi.wdata, axi.wstrb} !== {32'h12345678, 4'hF}) $display("FAIL wr_w_fields: got %h %h exp 12345678 f", axi.wdata, axi.wstrb); else n_pass++;
        axi.wready = 1; step(); axi.wready = 0;
        n_chk++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) $display("FAIL wr_w_drop: got aw/w/b %b exp 100", {axi.awvalid, axi.wvalid, axi.bready}); else n_pass++;
        step();
        n_chk++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) $display("FAIL wr_aw_hold: got aw/w/b %b exp 100", {axi.awvalid, axi.wvalid, axi.bready}); else n_pass++;
        axi.awready = 1; step(); axi.awready = 0;
        n_chk++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) $display("FAIL wr_bready_rise: got aw/w/b %b exp 001", {axi.awvalid, axi.wvalid, axi.bready}); else n_pass++;
        axi.bvalid = 1; axi.bid = 6'd9; axi.bresp = 2'b00; step(); axi.bvalid = 0;
        n_chk++; if ({rsp_valid, rsp_resp, rsp_id} !== {1'b1, 2'b00, 6'd9}) $display("FAIL wr_rsp: got v %b resp %0d id %0d exp 1 0 9", rsp_valid, rsp_resp, rsp_id); else n_pass++;
        n_chk++; if (rsp_rdata !== 32'h0) $display("FAIL wr_rsp_rdata: got %h exp 0", rsp_rdata); else n_pass++;
        n_chk++; if (axi.bready !== 1'b0) $display("FAIL wr_bready_drop: got %b exp 0", axi.bready); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        put_req(1, 32'h40, 32'h0, 4'h0, 6'd1);
        step();
        // next request waits on the port while the read is outstanding
        put_req(0, 32'h80, 32'hA5A5A5A5, 4'h3, 6'd2);
        n_chk++; if ({axi.arvalid, axi.awvalid, req_ready} !== 3'b100) $display("FAIL b2b_rd_only: got ar/aw/ready %b exp 100", {axi.arvalid, axi.awvalid, req_ready}); else n_pass++;
        axi.arready = 1; step(); axi.arready = 0;
        n_chk++; if ({axi.arvalid, axi.awvalid, axi.wvalid, req_ready} !== 4'b0000) $display("FAIL b2b_no_second: got %b exp 0000", {axi.arvalid, axi.awvalid, axi.wvalid, req_ready}); else n_pass++;
        axi.rvalid = 1; axi.rid = 6'd1; axi.rdata = 32'hCAFE0001; axi.rresp = 2'b01;
        step(); axi.rvalid = 0;
        n_chk++; if ({rsp_valid, req_ready} !== 2'b11) $display("FAIL b2b_rsp_ready: got %b exp 11", {rsp_valid, req_ready}); else n_pass++;
        n_chk++; if ({rsp_rdata, rsp_resp, rsp_id} !== {32'hCAFE0001, 2'b01, 6'd1}) $display("FAIL b2b_rd_rsp: got %h %0d %0d", rsp_rdata, rsp_resp, rsp_id); else n_pass++;
        step(); req_valid = 0;
        n_chk++; if ({rsp_valid, axi.awvalid, axi.wvalid, axi.arvalid} !== 4'b0110) $display("FAIL b2b_wr_issue: got %b exp 0110", {rsp_valid, axi.awvalid, axi.wvalid, axi.arvalid}); else n_pass++;
        n_chk++; if ({axi.awaddr, axi.wdata, axi.wstrb} !== {32'h80, 32'hA5A5A5A5, 4'h3}) $display("FAIL b2b_wr_fields: got %h %h %h", axi.awaddr, axi.wdata, axi.wstrb); else n_pass++;
        axi.awready = 1; axi.wready = 1; step(); axi.awready = 0; axi.wready = 0;
        n_chk++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) $display("FAIL b2b_same_cycle: got %b exp 001", {axi.awvalid, axi.wvalid, axi.bready}); else n_pass++;
        axi.bvalid = 1; axi.bid = 6'd2; axi.bresp = 2'b10; step(); axi.bvalid = 0;
        n_chk++; if ({rsp_valid, rsp_resp, rsp_id} !== {1'b1, 2'b10, 6'd2}) $display("FAIL b2b_wr_rsp: got v %b resp %0d id %0d exp 1 2 2", rsp_valid, rsp_resp, rsp_id); else n_pass++;
        step();
    endtask

    task automatic test_id_mismatch();
        put_req(1, 32'h500, 32'h0, 4'h0, 6'd3);
        step(); req_valid = 0;
        axi.arready = 1; step(); axi.arready = 0;
        axi.rvalid = 1; axi.rid = 6'd4; axi.rdata = 32'h11112222; axi.rresp = 2'b00;
        step(); axi.rvalid = 0;
        n_chk++; if ({rsp_valid, rsp_resp, rsp_id} !== {1'b1, EXP_BAD_RESP, 6'd3}) $display("FAIL idm_rsp: got v %b resp %0d id %0d exp 1 %0d 3", rsp_valid, rsp_resp, rsp_id, EXP_BAD_RESP); else n_pass++;
        n_chk++; if (id_err !== EXP_ERR) $display("FAIL idm_err_set: got %b exp %b", id_err, EXP_ERR); else n_pass++;
        step();
        put_req(0, 32'h600, 32'h99, 4'h1, 6'd6);
        step(); req_valid = 0;
        axi.awready = 1; axi.wready = 1; step(); axi.awready = 0; axi.wready = 0;
        axi.bvalid = 1; axi.bid = 6'd6; axi.bresp = 2'b00; step(); axi.bvalid = 0;
        n_chk++; if ({rsp_valid, rsp_resp} !== 3'b100) $display("FAIL idm_good_rsp: got v %b resp %0d exp 1 0", rsp_valid, rsp_resp); else n_pass++;
        n_chk++; if (id_err !== EXP_ERR) $display("FAIL idm_err_sticky: got %b exp %b", id_err, EXP_ERR); else n_pass++;
        step();
    endtask

    task automatic test_async_reset();
        put_req(1, 32'h3000, 32'h0, 4'h0, 6'd7);
        step(); req_valid = 0;
        // reset between edges while arvalid is high
        #2 rst = 1; #1;
        n_chk++; if ({axi.arvalid, req_ready} !== 2'b01) $display("FAIL arst_ar: got arvalid/ready %b exp 01", {axi.arvalid, req_ready}); else n_pass++;
        @(negedge clk); rst = 0;
        step();
        put_req(1, 32'h3000, 32'h0, 4'h0, 6'd7);
        step(); req_valid = 0;
        axi.arready = 1; step(); axi.arready = 0;
        n_chk++; if (axi.rready !== 1'b1) $display("FAIL arst_in_rresp: got %b exp 1", axi.rready); else n_pass++;
        #3 rst = 1; #1;
        n_chk++; if ({axi.arvalid, axi.rready, rsp_valid} !== 3'b000) $display("FAIL arst_drop: got %b exp 000", {axi.arvalid, axi.rready, rsp_valid}); else n_pass++;
        n_chk++; if ({req_ready, id_err} !== 2'b10) $display("FAIL arst_ready_err: got %b exp 10", {req_ready, id_err}); else n_pass++;
        @(negedge clk); rst = 0;
        step();
        put_req(1, 32'h4000, 32'h0, 4'h0, 6'd8);
        step(); req_valid = 0;
        n_chk++; if ({axi.arvalid, axi.araddr, axi.arid} !== {1'b1, 32'h4000, 6'd8}) $display("FAIL arst_new_ar: got %b %h %0d", axi.arvalid, axi.araddr, axi.arid); else n_pass++;
        axi.arready = 1; step(); axi.arready = 0;
        axi.rvalid = 1; axi.rid = 6'd8; axi.rdata = 32'h0BADF00D; axi.rresp = 2'b00;
        step(); axi.rvalid = 0;
        n_chk++; if ({rsp_valid, rsp_rdata, rsp_id, rsp_resp} !== {1'b1, 32'h0BADF00D, 6'd8, 2'b00}) $display("FAIL arst_new_rsp: got %b %h %0d %0d", rsp_valid, rsp_rdata, rsp_id, rsp_resp); else n_pass++;
        step();
    endtask

    task automatic test_stray();
        axi.rvalid = 1; axi.bvalid = 1; axi.rid = 6'd0; axi.bid = 6'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if ({axi.rready, axi.bready, rsp_valid} !== 3'b000) $display("FAIL stray_%0d: got rready/bready/rsp %b exp 000", i, {axi.rready, axi.bready, rsp_valid}); else n_pass++;
        end
        axi.rvalid = 0; axi.bvalid = 0;
        step();
        n_chk++; if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL stray_after: got rsp/ready %b exp 01", {rsp_valid, req_ready}); else n_pass++;
    endtask

    initial begin
        slave_idle();
        test_reset();
        test_read();
        test_write_w_first();
        test_back_to_back();
        test_id_mismatch();
        test_async_reset();
        test_stray();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
